// File: rtl/demux32_fifo.sv
// demux32_fifo: registered 1-to-4 demultiplexer with one FIFO per destination.
//
// Each accepted word is written into FIFO[in_sel]. Each FIFO drains through
// its own valid/ready handshake.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_data, in_sel       word to route and its destination (0..3)
//   in_valid / in_ready   producer handshake; in_ready = destination not full
//   out_dataN             head word of channel N (storage at its read pointer)
//   out_validN            channel N non-empty
//   out_readyN            consumer N takes the head word this cycle
module demux32_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic             out_valid3,
  input  logic             out_ready0,
  input  logic             out_ready1,
  input  logic             out_ready2,
  input  logic             out_ready3
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]       out_ready_vec;
  logic [3:0]       out_valid_vec;
  logic [3:0]       full_vec;
  logic [WIDTH-1:0] head [4];

  assign out_ready_vec = {out_ready3, out_ready2, out_ready1, out_ready0};

  // Derived only from registered counts and in_sel, so a consumer popping a
  // full channel in the same cycle does not open a path to in_ready.
  assign in_ready = !full_vec[in_sel];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic [WIDTH-1:0] mem_reg [DEPTH];
      logic [PW-1:0]    wr_ptr_reg;
      logic [PW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;
      logic             push;
      logic             pop;

      assign push = in_valid && in_ready && (in_sel == 2'(gi));
      // Popping an empty channel is ignored.
      assign pop  = out_valid_vec[gi] && out_ready_vec[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
          end
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) begin
            mem_reg[wr_ptr_reg] <= in_data;
            // DEPTH is a power of two, so the natural overflow wraps to 0.
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
          end
          case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

      assign full_vec[gi]      = (count_reg == CW'(DEPTH));
      assign out_valid_vec[gi] = (count_reg != '0);
      assign head[gi]          = mem_reg[rd_ptr_reg];
    end
  endgenerate

  assign out_data0  = head[0];
  assign out_data1  = head[1];
  assign out_data2  = head[2];
  assign out_data3  = head[3];
  assign out_valid0 = out_valid_vec[0];
  assign out_valid1 = out_valid_vec[1];
  assign out_valid2 = out_valid_vec[2];
  assign out_valid3 = out_valid_vec[3];

endmodule

// File: tb/tb_demux32_fifo.sv
// tb_demux32_fifo: directed, table-driven bench for demux32_fifo (DEPTH=2).
// Each vector is applied at the falling edge. in_ready, out_valid[3:0] and
// the masked out_data values are then checked before the next rising edge
// commits the vector. The expected outputs describe the state left by the
// earlier vectors.
module tb_demux32_fifo;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [3:0][31:0] od;
  logic [3:0]       ov;
  logic [3:0]       ordy;

  always #5 clk = ~clk;

  demux32_fifo #(.WIDTH(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data0  (od[0]),
    .out_data1  (od[1]),
    .out_data2  (od[2]),
    .out_data3  (od[3]),
    .out_valid0 (ov[0]),
    .out_valid1 (ov[1]),
    .out_valid2 (ov[2]),
    .out_valid3 (ov[3]),
    .out_ready0 (ordy[0]),
    .out_ready1 (ordy[1]),
    .out_ready2 (ordy[2]),
    .out_ready3 (ordy[3])
  );

  typedef struct {
    logic             v;
    logic [1:0]       sel;
    logic [31:0]      d;
    logic [3:0]       rdy;
    logic             e_ir;
    logic [3:0]       e_val;
    logic [3:0]       e_mask;
    logic [3:0][31:0] e_d;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic v, input logic [1:0] sel, input logic [31:0] d,
                     input logic [3:0] rdy, input logic e_ir, input logic [3:0] e_val,
                     input logic [3:0] e_mask, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic [31:0] d3);
    vec_t t;
    t.v = v; t.sel = sel; t.d = d; t.rdy = rdy;
    t.e_ir = e_ir; t.e_val = e_val; t.e_mask = e_mask;
    t.e_d[0] = d0; t.e_d[1] = d1; t.e_d[2] = d2; t.e_d[3] = d3;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      in_valid = vecs[i].v;
      in_sel   = vecs[i].sel;
      in_data  = vecs[i].d;
      ordy     = vecs[i].rdy;
      #1;
      chk("in_ready", i, 32'(in_ready), 32'(vecs[i].e_ir));
      chk("out_valid", i, 32'(ov), 32'(vecs[i].e_val));
      for (int c = 0; c < 4; c++) begin
        if (vecs[i].e_mask[c]) chk($sformatf("out_data%0d", c), i, od[c], vecs[i].e_d[c]);
      end
      $display("vec %0d: v=%0d sel=%0d d=%h rdy=%b -> in_ready=%0d valid=%b",
               i, in_valid, in_sel, in_data, ordy, in_ready, ov);
    end
  endtask

  initial begin
    // Columns: v sel data rdy | e_ir e_val mask d0 d1 d2 d3
    // Single route to channel 2, then pop it.
    add(0, 0, 32'h0,        4'b0000, 1, 4'b0000, 4'b1111, 0, 0, 0, 0);            // 0
    add(1, 2, 32'hDEADBEEF, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);            // 1
    add(0, 0, 32'h0,        4'b0100, 1, 4'b0100, 4'b0100, 0, 0, 32'hDEADBEEF, 0); // 2
    add(0, 0, 32'h0,        4'b0000, 1, 4'b0000, 4'b0100, 0, 0, 0, 0);            // 3
    // Fill channel 1 and stall, then pop once and accept the held word.
    add(1, 1, 32'h11,       4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);            // 4
    add(1, 1, 32'h22,       4'b0000, 1, 4'b0010, 4'b0010, 0, 32'h11, 0, 0);       // 5
    add(1, 1, 32'h33,       4'b0000, 0, 4'b0010, 4'b0010, 0, 32'h11, 0, 0);       // 6
    add(1, 1, 32'h33,       4'b0010, 0, 4'b0010, 4'b0010, 0, 32'h11, 0, 0);       // 7
    add(1, 1, 32'h33,       4'b0000, 1, 4'b0010, 4'b0010, 0, 32'h22, 0, 0);       // 8
    add(0, 1, 32'h0,        4'b0010, 0, 4'b0010, 4'b0010, 0, 32'h22, 0, 0);       // 9
    add(0, 1, 32'h0,        4'b0010, 1, 4'b0010, 4'b0010, 0, 32'h33, 0, 0);       // 10
    add(0, 1, 32'h0,        4'b0000, 1, 4'b0000, 4'b0010, 0, 32'h22, 0, 0);       // 11
    // Simultaneous push/pop on channel 3 across several pointer wraps.
    add(1, 3, 32'hA,        4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);            // 12
    add(1, 3, 32'hB,        4'b1000, 1, 4'b1000, 4'b1000, 0, 0, 0, 32'hA);        // 13
    add(1, 3, 32'hC,        4'b1000, 1, 4'b1000, 4'b1000, 0, 0, 0, 32'hB);        // 14
    add(1, 3, 32'hD,        4'b1000, 1, 4'b1000, 4'b1000, 0, 0, 0, 32'hC);        // 15
    add(1, 3, 32'hE,        4'b1000, 1, 4'b1000, 4'b1000, 0, 0, 0, 32'hD);        // 16
    add(1, 3, 32'hF,        4'b1000, 1, 4'b1000, 4'b1000, 0, 0, 0, 32'hE);        // 17
    add(0, 3, 32'h0,        4'b1000, 1, 4'b1000, 4'b1000, 0, 0, 0, 32'hF);        // 18
    add(0, 3, 32'h0,        4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);            // 19
    // Channel 0 full and stalled while channel 2 still accepts.
    add(1, 0, 32'h51,       4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);            // 20
    add(1, 0, 32'h52,       4'b0000, 1, 4'b0001, 4'b0001, 32'h51, 0, 0, 0);       // 21
    add(1, 2, 32'h55,       4'b0000, 1, 4'b0001, 4'b0001, 32'h51, 0, 0, 0);       // 22
    add(1, 0, 32'h60,       4'b0000, 0, 4'b0101, 4'b0101, 32'h51, 0, 32'h55, 0);  // 23
    // After the asynchronous reset: a single delivery, then pops on empty.
    add(1, 0, 32'h77,       4'b0000, 1, 4'b0000, 4'b1111, 0, 0, 0, 0);            // 24
    add(0, 0, 32'h0,        4'b0000, 1, 4'b0001, 4'b0001, 32'h77, 0, 0, 0);       // 25
    add(0, 0, 32'h0,        4'b0001, 1, 4'b0001, 4'b0001, 32'h77, 0, 0, 0);       // 26
    add(0, 0, 32'h0,        4'b0001, 1, 4'b0000, 4'b0001, 0, 0, 0, 0);            // 27
    add(0, 0, 32'h0,        4'b0001, 1, 4'b0000, 4'b0001, 0, 0, 0, 0);            // 28
    add(0, 0, 32'h0,        4'b0001, 1, 4'b0000, 4'b0001, 0, 0, 0, 0);            // 29
    add(1, 0, 32'h99,       4'b0001, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);            // 30
    add(0, 0, 32'h0,        4'b0001, 1, 4'b0001, 4'b0001, 32'h99, 0, 0, 0);       // 31
    add(0, 0, 32'h0,        4'b0000, 1, 4'b0000, 4'b0001, 32'h77, 0, 0, 0);       // 32

    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 32'h0; ordy = 4'b0000;
    #1;
    chk("reset_valid", -1, 32'(ov), 32'h0);
    for (int c = 0; c < 4; c++) chk($sformatf("reset_data%0d", c), -1, od[c], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", -1, 32'(in_ready), 32'h1);

    run(0, 23);

    // Asynchronous reset between edges with channels 0 and 2 occupied.
    @(posedge clk);
    #2;
    chk("pre_reset_valid", -2, 32'(ov), 32'b0101);
    in_valid = 1'b0;
    ordy     = 4'b0000;
    rst_n    = 1'b0;
    #1;
    chk("async_reset_valid", -2, 32'(ov), 32'h0);
    for (int c = 0; c < 4; c++) chk($sformatf("async_reset_data%0d", c), -2, od[c], 32'h0);
    $display("async reset: valid=%b data0=%h data2=%h", ov, od[0], od[2]);
    @(negedge clk);
    rst_n = 1'b1;

    run(24, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
